bsg_fsb_murn_node_rx: RTL and testbench

Node-side receive stage placed directly downstream of the FSB murn gateway. Accepts packets the gateway forwards for this node, buffers them in a 2-entry FIFO, and strips the FSB header so the node sees only payload. Also converts the gateway's enable/reset control bits into a clean, stretched node reset and a delivery gate.

---
 rtl/bsg_fsb_murn_node_rx.sv | 122 ++++++++++++
 tb/tb_bsg_fsb_murn_node_rx.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/bsg_fsb_murn_node_rx.sv
// rtl/bsg_fsb_murn_node_rx.sv - node-side FSB receive stage: 2-entry payload FIFO, header strip, stretched node reset (optional delivery counter: BSG_FSB_MURN_NODE_RX_COUNT_EN)
module bsg_fsb_murn_node_rx #(
    parameter int width_p      = 64,
    parameter int id_width_p   = 4,
    parameter int reset_hold_p = 4,
    localparam int pw_lp       = width_p - id_width_p - 1
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    input  logic               node_en_i,
    input  logic               node_reset_i,
    output logic               v_o,
    output logic [pw_lp-1:0]   data_o,
    input  logic               yumi_i,
    output logic               node_reset_o,
    output logic [15:0]        count_o
);

    localparam int hold_w_lp = (reset_hold_p > 1) ? $clog2(reset_hold_p) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ASSERT,
        S_HOLD
    } state_e;

    state_e                 state_r, state_n;
    logic [hold_w_lp-1:0]   hold_cnt_r, hold_cnt_n;

    logic [pw_lp-1:0]       mem_r [2];
    logic                   wptr_r, rptr_r;
    logic [1:0]             occ_r;
    logic                   full, empty, enq, deq;

    // Header bits (id + cmd) are intentionally dropped; only payload is stored.
    logic                   unused_hdr;
    assign unused_hdr = ^data_i[width_p-1:pw_lp];

    // Reset stretcher state register; reset_i forces ASSERT from any state.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r    <= S_ASSERT;
            hold_cnt_r <= '0;
        end else begin
            state_r    <= state_n;
            hold_cnt_r <= hold_cnt_n;
        end
    end

    // Reset stretcher next-state: hold node reset for reset_hold_p cycles after sources drop.
    always_comb begin
        state_n    = state_r;
        hold_cnt_n = hold_cnt_r;
        case (state_r)
            S_IDLE: begin
                if (node_reset_i) state_n = S_ASSERT;
            end
            S_ASSERT: begin
                hold_cnt_n = '0;
                if (!node_reset_i) state_n = S_HOLD;
            end
            S_HOLD: begin
                if (node_reset_i) begin
                    state_n    = S_ASSERT;
                    hold_cnt_n = '0;
                end else if (hold_cnt_r == hold_w_lp'(reset_hold_p - 1)) begin
                    state_n    = S_IDLE;
                    hold_cnt_n = '0;
                end else begin
                    hold_cnt_n = hold_cnt_r + hold_w_lp'(1);
                end
            end
            default: state_n = S_ASSERT;
        endcase
    end

    assign node_reset_o = (state_r != S_IDLE);

    assign full    = (occ_r == 2'd2);
    assign empty   = (occ_r == 2'd0);
    assign ready_o = ~full & ~node_reset_o;
    assign v_o     = ~empty & node_en_i & ~node_reset_o;
    assign enq     = v_i & ready_o;
    assign deq     = yumi_i & v_o;
    assign data_o  = mem_r[rptr_r];

    // FIFO pointers and occupancy; held empty while the node is in reset.
    always_ff @(posedge clk_i) begin
        if (reset_i || node_reset_o) begin
            wptr_r <= 1'b0;
            rptr_r <= 1'b0;
            occ_r  <= 2'd0;
        end else begin
            if (enq) wptr_r <= ~wptr_r;
            if (deq) rptr_r <= ~rptr_r;
            occ_r <= occ_r + 2'(enq) - 2'(deq);
        end
    end

    // Payload storage; no reset needed since occupancy guards visibility.
    always_ff @(posedge clk_i) begin
        if (enq) mem_r[wptr_r] <= data_i[pw_lp-1:0];
    end

`ifdef BSG_FSB_MURN_NODE_RX_COUNT_EN
    logic [15:0] count_r;

    // Delivered-packet counter, wraps naturally at 16 bits.
    always_ff @(posedge clk_i) begin
        if (reset_i || node_reset_o) count_r <= 16'h0;
        else if (deq)                count_r <= count_r + 16'h1;
    end

    assign count_o = count_r;
`else
    assign count_o = 16'h0;
`endif

endmodule

// File: tb/tb_bsg_fsb_murn_node_rx.sv
// tb/tb_bsg_fsb_murn_node_rx.sv - directed self-checking bench for bsg_fsb_murn_node_rx
module tb_bsg_fsb_murn_node_rx;

`ifdef BSG_FSB_MURN_NODE_RX_COUNT_EN
    localparam bit cnt_en = 1'b1;
`else
    localparam bit cnt_en = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        v_i;
    logic [63:0] data_i;
    logic        ready_o;
    logic        node_en_i;
    logic        node_reset_i;
    logic        v_o;
    logic [58:0] data_o;
    logic        yumi_i;
    logic        node_reset_o;
    logic [15:0] count_o;

    int checks   = 0;
    int failures = 0;
    int delivered = 0;

    bsg_fsb_murn_node_rx #(
        .width_p(64),
        .id_width_p(4),
        .reset_hold_p(4)
    ) dut (
        .clk_i(clk_i),
        .reset_i(reset_i),
        .v_i(v_i),
        .data_i(data_i),
        .ready_o(ready_o),
        .node_en_i(node_en_i),
        .node_reset_i(node_reset_i),
        .v_o(v_o),
        .data_o(data_o),
        .yumi_i(yumi_i),
        .node_reset_o(node_reset_o),
        .count_o(count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] exp_count(input int n);
        return cnt_en ? 64'(n & 16'hFFFF) : 64'h0;
    endfunction

    function automatic logic [63:0] pkt(input logic [3:0] id, input logic [58:0] pl);
        return {id, 1'b1, pl};
    endfunction

    initial begin
        reset_i = 1'b1; v_i = 1'b0; data_i = '0;
        node_en_i = 1'b0; node_reset_i = 1'b0; yumi_i = 1'b0;

        // reset held for 3 edges
        tick(); tick(); tick();
        chk("rst_v_o", 64'(v_o), 0);
        chk("rst_ready_o", 64'(ready_o), 0);
        chk("rst_node_reset_o", 64'(node_reset_o), 1);
        chk("rst_count_o", 64'(count_o), 0);

        // release: node_reset_o stays high 5 more cycles
        reset_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("hold_nro_%0d", i), 64'(node_reset_o), 1);
            chk($sformatf("hold_ready_%0d", i), 64'(ready_o), 0);
            tick();
        end
        chk("rel_node_reset_o", 64'(node_reset_o), 0);
        chk("rel_ready_o", 64'(ready_o), 1);

        // header strip and one-cycle latency
        node_en_i = 1'b1; yumi_i = 1'b1; v_i = 1'b1;
        data_i = 64'hA801_2345_6789_ABCD;
        #1;
        chk("hs_no_bypass", 64'(v_o), 0);
        tick();
        v_i = 1'b0; #1;
        chk("hs_v_o", 64'(v_o), 1);
        chk("hs_data_o", 64'(data_o), 64'h0001_2345_6789_ABCD);
        delivered++;
        tick();
        chk("hs_drained", 64'(v_o), 0);
        chk("hs_count", 64'(count_o), exp_count(delivered));

        // back-to-back throughput with yumi held high
        for (int k = 0; k < 3; k++) begin
            v_i = 1'b1; data_i = pkt(4'h3, 59'(64'h100 + k));
            #1;
            chk($sformatf("b2b_ready_%0d", k), 64'(ready_o), 1);
            if (k > 0) begin
                chk($sformatf("b2b_v_%0d", k), 64'(v_o), 1);
                chk($sformatf("b2b_d_%0d", k), 64'(data_o), 64'h100 + k - 1);
                delivered++;
            end
            tick();
        end
        v_i = 1'b0; #1;
        chk("b2b_last_d", 64'(data_o), 64'h102);
        delivered++;
        tick();
        chk("b2b_empty", 64'(v_o), 0);

        // full / backpressure: third packet refused
        yumi_i = 1'b0;
        v_i = 1'b1; data_i = pkt(4'h5, 59'h111); #1;
        chk("bp_ready0", 64'(ready_o), 1);
        tick();
        data_i = pkt(4'h5, 59'h222); #1;
        chk("bp_ready1", 64'(ready_o), 1);
        tick();
        data_i = pkt(4'h5, 59'h333); #1;
        chk("bp_ready_full", 64'(ready_o), 0);
        tick();
        v_i = 1'b0; yumi_i = 1'b1; #1;
        chk("bp_head", 64'(data_o), 64'h111);
        chk("bp_still_full", 64'(ready_o), 0);
        delivered++;
        tick();
        chk("bp_ready_back", 64'(ready_o), 1);
        chk("bp_second_v", 64'(v_o), 1);
        chk("bp_second_d", 64'(data_o), 64'h222);
        delivered++;
        tick();
        chk("bp_third_dropped", 64'(v_o), 0);
        yumi_i = 1'b0;

        // enable gating: two entries held while node_en_i=0
        node_en_i = 1'b0;
        v_i = 1'b1; data_i = pkt(4'h7, 59'h7AAA); tick();
        data_i = pkt(4'h7, 59'h7BBB); tick();
        v_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk($sformatf("gate_v_%0d", i), 64'(v_o), 0);
            chk($sformatf("gate_full_%0d", i), 64'(ready_o), 0);
            tick();
        end
        node_en_i = 1'b1; #1;
        chk("gate_v_on", 64'(v_o), 1);
        chk("gate_d0", 64'(data_o), 64'h7AAA);
        yumi_i = 1'b1; delivered++;
        tick();
        chk("gate_d1", 64'(data_o), 64'h7BBB);
        delivered++;
        tick();
        yumi_i = 1'b0; #1;
        chk("gate_empty", 64'(v_o), 0);
        chk("gate_count", 64'(count_o), exp_count(delivered));

        // mid-traffic flush
        v_i = 1'b1; data_i = pkt(4'h9, 59'h5111); tick();
        data_i = pkt(4'h9, 59'h5222); tick();
        v_i = 1'b0; node_reset_i = 1'b1;
        tick();
        node_reset_i = 1'b0;
        v_i = 1'b1; data_i = pkt(4'h9, 59'hDEAD);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("fl_nro_%0d", i), 64'(node_reset_o), 1);
            chk($sformatf("fl_v_%0d", i), 64'(v_o), 0);
            chk($sformatf("fl_ready_%0d", i), 64'(ready_o), 0);
            tick();
        end
        v_i = 1'b0; #1;
        delivered = 0;
        chk("fl_nro_done", 64'(node_reset_o), 0);
        chk("fl_ready", 64'(ready_o), 1);
        chk("fl_emptied", 64'(v_o), 0);
        chk("fl_count", 64'(count_o), exp_count(delivered));
        v_i = 1'b1; data_i = pkt(4'h2, 59'h6666); tick();
        v_i = 1'b0; yumi_i = 1'b1; #1;
        chk("fl_new_v", 64'(v_o), 1);
        chk("fl_new_d", 64'(data_o), 64'h6666);
        delivered++;
        tick();
        yumi_i = 1'b0; #1;
        chk("fl_new_count", 64'(count_o), exp_count(delivered));

`ifdef BSG_FSB_MURN_NODE_RX_COUNT_EN
        // 65536 more deliveries wrap the counter back to 1
        v_i = 1'b1; yumi_i = 1'b1; data_i = pkt(4'h1, 59'h1);
        for (int i = 0; i < 65536; i++) begin
            @(posedge clk_i);
        end
        #1;
        v_i = 1'b0;
        tick();
        yumi_i = 1'b0;
        delivered += 65536;
        #1;
        chk("wrap_count", 64'(count_o), exp_count(delivered));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
